except_ctrl: RTL and testbench

Exception/interrupt sequencing controller for the CP0 register block. It samples writeback-stage exception flags and the CP0 interrupt state, and selects one exception by priority. It drives the CP0 update strobes (except, excode, badvaddr, eret, gated mtc0), then sequences a pipeline flush and a handshaked PC redirect to the exception vector or EPC.

---
 rtl/except_ctrl.sv | 164 ++++++++++++++++
 tb/tb_except_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/except_ctrl.sv
// Exception/interrupt sequencing controller for the CP0 register block.
// Picks one writeback-stage exception (or a pending interrupt) by priority,
// drives the CP0 update strobes, then flushes the pipeline for a fixed
// number of cycles and hands a redirect target to fetch with a
// valid/ready handshake.
module except_ctrl #(
  parameter int unsigned FLUSH_CYCLES  = 2,
  parameter logic [31:0] EXC_VECTOR    = 32'hBFC00380,
  parameter logic [31:0] EXC_VECTOR_NB = 32'h80000180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_bd,
  input  logic [31:0] wb_mem_addr,
  input  logic        wb_exc_adel_if,
  input  logic        wb_exc_ri,
  input  logic        wb_exc_ov,
  input  logic        wb_exc_sys,
  input  logic        wb_exc_bp,
  input  logic        wb_exc_adel_mem,
  input  logic        wb_exc_ades,
  input  logic        wb_eret,
  input  logic        wb_mtc0,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic        status_bev,
  input  logic [7:0]  status_im,
  input  logic [7:0]  cause_ip,
  input  logic [31:0] c0_epc,
  output logic        cp0_except,
  output logic [4:0]  cp0_excode,
  output logic [31:0] cp0_badvaddr,
  output logic        cp0_bd,
  output logic        cp0_eret,
  output logic        cp0_mtc0_we,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t      state;
  state_t      state_next;
  logic [3:0]  count;
  logic [3:0]  count_next;
  logic [31:0] target;
  logic [31:0] target_next;
  logic        int_req;
  logic        int_pending;
  logic        accept;
  logic        any_flag;
  logic        exc;

  // Interrupt condition as seen this cycle; registered below for one cycle of latency.
  assign int_pending = status_ie & ~status_exl & (|(status_im & cause_ip));

  // Priority encoder and CP0 strobes; gated by reset so outputs drop immediately.
  always_comb begin
    accept       = (state == IDLE) & wb_valid & ~reset;
    any_flag     = wb_exc_adel_if | wb_exc_ri | wb_exc_ov | wb_exc_sys |
                   wb_exc_bp | wb_exc_adel_mem | wb_exc_ades;
    exc          = accept & (any_flag | int_req);
    cp0_excode   = 5'h00;
    cp0_badvaddr = 32'h0;
    if (exc) begin
      if (int_req) begin
        cp0_excode = 5'h00;
      end else if (wb_exc_adel_if) begin
        cp0_excode   = 5'h04;
        cp0_badvaddr = wb_pc;
      end else if (wb_exc_ri) begin
        cp0_excode = 5'h0A;
      end else if (wb_exc_ov) begin
        cp0_excode = 5'h0C;
      end else if (wb_exc_sys) begin
        cp0_excode = 5'h08;
      end else if (wb_exc_bp) begin
        cp0_excode = 5'h09;
      end else if (wb_exc_adel_mem) begin
        cp0_excode   = 5'h04;
        cp0_badvaddr = wb_mem_addr;
      end else begin
        cp0_excode   = 5'h05;
        cp0_badvaddr = wb_mem_addr;
      end
    end
    cp0_except  = exc;
    cp0_bd      = wb_bd & exc;
    cp0_eret    = accept & wb_eret & ~exc;
    cp0_mtc0_we = accept & wb_mtc0 & ~exc;
  end

  // Next-state, flush counter, redirect target and fetch-side outputs.
  always_comb begin
    state_next     = state;
    count_next     = count;
    target_next    = target;
    flush          = exc | cp0_eret | (state == FLUSH);
    redirect_valid = (state == REDIRECT);
    redirect_pc    = (state == REDIRECT) ? target : 32'h0;
    case (state)
      IDLE: begin
        if (exc) begin
          target_next = status_bev ? EXC_VECTOR : EXC_VECTOR_NB;
          count_next  = FLUSH_LOAD;
          state_next  = FLUSH;
        end else if (cp0_eret) begin
          target_next = c0_epc;
          count_next  = FLUSH_LOAD;
          state_next  = FLUSH;
        end
      end
      FLUSH: begin
        count_next = count - 4'd1;
        if (count == 4'd1) begin
          state_next = REDIRECT;
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counter and target registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= 4'd0;
      target <= 32'h0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      target <= target_next;
    end
  end

  // Interrupt request register; cleared when an exception is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_req <= 1'b0;
    end else if (exc) begin
      int_req <= 1'b0;
    end else begin
      int_req <= int_pending;
    end
  end

endmodule

// File: tb/tb_except_ctrl.sv
// Testbench for except_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-count reference model.
module tb_except_ctrl;

  localparam int          FC    = 2;
  localparam logic [31:0] VEC   = 32'hBFC00380;
  localparam logic [31:0] VECNB = 32'h80000180;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid, wb_bd, wb_eret, wb_mtc0;
  logic [31:0] wb_pc, wb_mem_addr, c0_epc;
  logic        wb_exc_adel_if, wb_exc_ri, wb_exc_ov, wb_exc_sys, wb_exc_bp;
  logic        wb_exc_adel_mem, wb_exc_ades;
  logic        status_ie, status_exl, status_bev;
  logic [7:0]  status_im, cause_ip;
  logic        cp0_except, cp0_bd, cp0_eret, cp0_mtc0_we, flush;
  logic [4:0]  cp0_excode;
  logic [31:0] cp0_badvaddr, redirect_pc;
  logic        redirect_valid, redirect_ready;

  int checks = 0;
  int errors = 0;

  // Reference model state: pending interrupt, flush cycles still to run,
  // redirect pending, redirect target.
  bit          m_int;
  int          m_flush_left;
  bit          m_redir;
  logic [31:0] m_target;

  // Expected combinational outputs for the current cycle.
  logic        e_except, e_bd, e_eret, e_mtc0, e_flush, e_rv;
  logic [4:0]  e_code;
  logic [31:0] e_bad, e_rpc;

  except_ctrl #(.FLUSH_CYCLES(FC), .EXC_VECTOR(VEC), .EXC_VECTOR_NB(VECNB)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_bd(wb_bd),
    .wb_mem_addr(wb_mem_addr), .wb_exc_adel_if(wb_exc_adel_if), .wb_exc_ri(wb_exc_ri),
    .wb_exc_ov(wb_exc_ov), .wb_exc_sys(wb_exc_sys), .wb_exc_bp(wb_exc_bp),
    .wb_exc_adel_mem(wb_exc_adel_mem), .wb_exc_ades(wb_exc_ades), .wb_eret(wb_eret),
    .wb_mtc0(wb_mtc0), .status_ie(status_ie), .status_exl(status_exl),
    .status_bev(status_bev), .status_im(status_im), .cause_ip(cause_ip), .c0_epc(c0_epc),
    .cp0_except(cp0_except), .cp0_excode(cp0_excode), .cp0_badvaddr(cp0_badvaddr),
    .cp0_bd(cp0_bd), .cp0_eret(cp0_eret), .cp0_mtc0_we(cp0_mtc0_we), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic clear_inputs();
    wb_valid = 0; wb_pc = 0; wb_bd = 0; wb_mem_addr = 0; wb_eret = 0; wb_mtc0 = 0;
    wb_exc_adel_if = 0; wb_exc_ri = 0; wb_exc_ov = 0; wb_exc_sys = 0; wb_exc_bp = 0;
    wb_exc_adel_mem = 0; wb_exc_ades = 0;
    status_ie = 0; status_exl = 0; status_bev = 0; status_im = 0; cause_ip = 0;
    c0_epc = 0; redirect_ready = 0;
  endtask

  task automatic model_reset();
    m_int = 0; m_flush_left = 0; m_redir = 0; m_target = 0;
  endtask

  // Expected outputs from the architectural rules: priority table lookup.
  task automatic model_eval();
    bit        flags [8];
    logic [4:0] codes [8];
    int        win;
    bit        accept;
    flags = '{m_int, wb_exc_adel_if, wb_exc_ri, wb_exc_ov, wb_exc_sys, wb_exc_bp,
              wb_exc_adel_mem, wb_exc_ades};
    codes = '{5'd0, 5'd4, 5'd10, 5'd12, 5'd8, 5'd9, 5'd4, 5'd5};
    win = -1;
    for (int i = 7; i >= 0; i--) if (flags[i]) win = i;
    accept   = !reset && wb_valid && m_flush_left == 0 && !m_redir;
    e_except = accept && win >= 0;
    e_code   = e_except ? codes[win] : 5'd0;
    e_bad    = !e_except ? 32'h0 : (win == 1) ? wb_pc : (win >= 6) ? wb_mem_addr : 32'h0;
    e_bd     = e_except && wb_bd;
    e_eret   = accept && wb_eret && !e_except;
    e_mtc0   = accept && wb_mtc0 && !e_except;
    e_flush  = e_except || e_eret || m_flush_left > 0;
    e_rv     = !reset && m_redir;
    e_rpc    = e_rv ? m_target : 32'h0;
  endtask

  task automatic model_update();
    bit pend;
    if (reset) begin
      model_reset();
      return;
    end
    pend = status_ie && !status_exl && ((status_im & cause_ip) != 0);
    m_int = e_except ? 1'b0 : pend;
    if (e_except) begin
      m_target = status_bev ? VEC : VECNB;
      m_flush_left = FC;
    end else if (e_eret) begin
      m_target = c0_epc;
      m_flush_left = FC;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
      if (m_flush_left == 0) m_redir = 1;
    end else if (m_redir && redirect_ready) begin
      m_redir = 0;
    end
  endtask

  // Advance one clock, keeping the model in step; returns 1ns after the edge.
  task automatic tick();
    model_eval();
    model_update();
    @(posedge clk);
    #1;
  endtask

  // Step with idle inputs until redirect_valid appears, bounded.
  task automatic wait_redirect();
    int n = 0;
    while (redirect_valid !== 1'b1 && n < 20) begin
      tick();
      #1;
      n++;
    end
    checks++;
    if (redirect_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wait_redirect: redirect_valid=%b required 1 within 20 cycles", redirect_valid);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    model_reset();
    reset = 1;
    wb_valid = 1; wb_exc_ov = 1; wb_eret = 1;
    #1;
    checks += 4;
    if (cp0_except !== 0) begin errors++; $display("[TB] FAIL reset_except: got %b want 0", cp0_except); end
    if (flush !== 0) begin errors++; $display("[TB] FAIL reset_flush: got %b want 0", flush); end
    if (redirect_valid !== 0) begin errors++; $display("[TB] FAIL reset_rv: got %b want 0", redirect_valid); end
    if (cp0_eret !== 0) begin errors++; $display("[TB] FAIL reset_eret: got %b want 0", cp0_eret); end
    tick(); tick();
    clear_inputs();
    @(negedge clk);
    reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    clear_inputs();
    wb_valid = 1; wb_exc_ov = 1; wb_pc = 32'h80001000; status_bev = 1;
    #1;
    checks += 4;
    if (cp0_except !== 1) begin errors++; $display("[TB] FAIL ov_except: got %b want 1", cp0_except); end
    if (cp0_excode !== 5'h0C) begin errors++; $display("[TB] FAIL ov_excode: got %h want 0c", cp0_excode); end
    if (flush !== 1) begin errors++; $display("[TB] FAIL ov_flush0: got %b want 1", flush); end
    if (cp0_badvaddr !== 0) begin errors++; $display("[TB] FAIL ov_badvaddr: got %h want 0", cp0_badvaddr); end
    tick();
    clear_inputs();
    for (int i = 0; i < FC; i++) begin
      #1;
      checks += 2;
      if (flush !== 1) begin errors++; $display("[TB] FAIL ov_flush%0d: got %b want 1", i + 1, flush); end
      if (redirect_valid !== 0) begin errors++; $display("[TB] FAIL ov_rv_early%0d: got %b want 0", i, redirect_valid); end
      tick();
    end
    #1;
    checks += 3;
    if (flush !== 0) begin errors++; $display("[TB] FAIL ov_flush_end: got %b want 0", flush); end
    if (redirect_valid !== 1) begin errors++; $display("[TB] FAIL ov_rv: got %b want 1", redirect_valid); end
    if (redirect_pc !== VEC) begin errors++; $display("[TB] FAIL ov_rpc: got %h want %h", redirect_pc, VEC); end
    redirect_ready = 1;
    tick();
    redirect_ready = 0;
    #1;
    checks++;
    if (redirect_valid !== 0) begin errors++; $display("[TB] FAIL ov_idle: got %b want 0", redirect_valid); end
  endtask

  task automatic test_interrupt();
    clear_inputs();
    status_ie = 1; status_im = 8'h80; cause_ip = 8'h80; wb_valid = 1;
    #1;
    checks++;
    if (cp0_except !== 0) begin errors++; $display("[TB] FAIL int_latency: got %b want 0", cp0_except); end
    tick();
    wb_bd = 1;
    #1;
    checks += 3;
    if (cp0_except !== 1) begin errors++; $display("[TB] FAIL int_except: got %b want 1", cp0_except); end
    if (cp0_excode !== 5'h00) begin errors++; $display("[TB] FAIL int_excode: got %h want 00", cp0_excode); end
    if (cp0_bd !== 1) begin errors++; $display("[TB] FAIL int_bd: got %b want 1", cp0_bd); end
    tick();
    clear_inputs();
    wait_redirect();
    checks++;
    if (redirect_pc !== VECNB) begin errors++; $display("[TB] FAIL int_rpc: got %h want %h", redirect_pc, VECNB); end
    redirect_ready = 1;
    tick();
    redirect_ready = 0;
  endtask

  task automatic test_eret_stall();
    clear_inputs();
    wb_valid = 1; wb_eret = 1; c0_epc = 32'h80002000;
    #1;
    checks += 3;
    if (cp0_eret !== 1) begin errors++; $display("[TB] FAIL eret_pulse: got %b want 1", cp0_eret); end
    if (cp0_except !== 0) begin errors++; $display("[TB] FAIL eret_noexc: got %b want 0", cp0_except); end
    if (flush !== 1) begin errors++; $display("[TB] FAIL eret_flush: got %b want 1", flush); end
    tick();
    clear_inputs();
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks += 2;
      if (redirect_valid !== 1) begin errors++; $display("[TB] FAIL eret_stall_rv%0d: got %b want 1", i, redirect_valid); end
      if (redirect_pc !== 32'h80002000) begin errors++; $display("[TB] FAIL eret_stall_pc%0d: got %h want 80002000", i, redirect_pc); end
      tick();
    end
    redirect_ready = 1;
    #1;
    checks++;
    if (redirect_valid !== 1) begin errors++; $display("[TB] FAIL eret_hs_rv: got %b want 1", redirect_valid); end
    tick();
    redirect_ready = 0;
    #1;
    checks++;
    if (redirect_valid !== 0) begin errors++; $display("[TB] FAIL eret_exit: got %b want 0", redirect_valid); end
  endtask

  task automatic test_simultaneous();
    clear_inputs();
    status_ie = 1; status_im = 8'h04; cause_ip = 8'h04;
    tick();
    wb_valid = 1; wb_exc_sys = 1; wb_eret = 1; wb_mtc0 = 1;
    #1;
    checks += 4;
    if (cp0_excode !== 5'h00) begin errors++; $display("[TB] FAIL sim_excode: got %h want 00", cp0_excode); end
    if (cp0_except !== 1) begin errors++; $display("[TB] FAIL sim_except: got %b want 1", cp0_except); end
    if (cp0_eret !== 0) begin errors++; $display("[TB] FAIL sim_eret: got %b want 0", cp0_eret); end
    if (cp0_mtc0_we !== 0) begin errors++; $display("[TB] FAIL sim_mtc0: got %b want 0", cp0_mtc0_we); end
    tick();
    clear_inputs();
    wait_redirect();
    redirect_ready = 1;
    tick();
    redirect_ready = 0;
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    wb_valid = 1; wb_exc_bp = 1; status_bev = 1;
    tick();
    clear_inputs();
    wb_valid = 1; wb_exc_ri = 1;
    for (int i = 0; i < FC; i++) begin
      #1;
      checks += 2;
      if (cp0_except !== 0) begin errors++; $display("[TB] FAIL squash_ri%0d: got %b want 0", i, cp0_except); end
      if (flush !== 1) begin errors++; $display("[TB] FAIL squash_flush%0d: got %b want 1", i, flush); end
      tick();
    end
    wb_exc_ri = 0; wb_mtc0 = 1;
    #1;
    checks += 2;
    if (cp0_mtc0_we !== 0) begin errors++; $display("[TB] FAIL squash_mtc0: got %b want 0", cp0_mtc0_we); end
    if (redirect_valid !== 1) begin errors++; $display("[TB] FAIL squash_rv: got %b want 1", redirect_valid); end
    redirect_ready = 1;
    tick();
    redirect_ready = 0; wb_mtc0 = 0;
    wb_exc_adel_mem = 1; wb_mem_addr = 32'h1235;
    #1;
    checks += 3;
    if (cp0_except !== 1) begin errors++; $display("[TB] FAIL b2b_except: got %b want 1", cp0_except); end
    if (cp0_excode !== 5'h04) begin errors++; $display("[TB] FAIL b2b_excode: got %h want 04", cp0_excode); end
    if (cp0_badvaddr !== 32'h1235) begin errors++; $display("[TB] FAIL b2b_badvaddr: got %h want 1235", cp0_badvaddr); end
    tick();
    clear_inputs();
    wait_redirect();
    redirect_ready = 1;
    tick();
    redirect_ready = 0;
  endtask

  task automatic test_reset_mid_redirect();
    clear_inputs();
    wb_valid = 1; wb_exc_ov = 1; status_bev = 1;
    tick();
    clear_inputs();
    wait_redirect();
    #2;
    reset = 1;
    #1;
    model_reset();
    checks += 3;
    if (redirect_valid !== 0) begin errors++; $display("[TB] FAIL rst_rv: got %b want 0", redirect_valid); end
    if (redirect_pc !== 0) begin errors++; $display("[TB] FAIL rst_rpc: got %h want 0", redirect_pc); end
    if (flush !== 0) begin errors++; $display("[TB] FAIL rst_flush: got %b want 0", flush); end
    @(negedge clk);
    reset = 0;
    @(posedge clk); #1;
    wb_valid = 1;
    #1;
    checks += 2;
    if (flush !== 0) begin errors++; $display("[TB] FAIL rst_after_flush: got %b want 0", flush); end
    if (redirect_valid !== 0) begin errors++; $display("[TB] FAIL rst_after_rv: got %b want 0", redirect_valid); end
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      wb_valid        = ($urandom_range(0, 3) != 0);
      wb_pc           = $urandom;
      wb_bd           = $urandom_range(0, 1) == 1;
      wb_mem_addr     = $urandom;
      wb_exc_adel_if  = $urandom_range(0, 11) == 0;
      wb_exc_ri       = $urandom_range(0, 11) == 0;
      wb_exc_ov       = $urandom_range(0, 11) == 0;
      wb_exc_sys      = $urandom_range(0, 11) == 0;
      wb_exc_bp       = $urandom_range(0, 11) == 0;
      wb_exc_adel_mem = $urandom_range(0, 11) == 0;
      wb_exc_ades     = $urandom_range(0, 11) == 0;
      wb_eret         = $urandom_range(0, 5) == 0;
      wb_mtc0         = $urandom_range(0, 3) == 0;
      status_ie       = $urandom_range(0, 1) == 1;
      status_exl      = $urandom_range(0, 1) == 1;
      status_bev      = $urandom_range(0, 1) == 1;
      status_im       = 8'($urandom);
      cause_ip        = 8'($urandom_range(0, 3) == 0 ? $urandom : 0);
      c0_epc          = $urandom;
      redirect_ready  = $urandom_range(0, 1) == 1;
      #1;
      model_eval();
      checks += 10;
      if (cp0_except !== e_except) begin errors++; $display("[TB] FAIL rnd_except@%0d: got %b want %b", n, cp0_except, e_except); end
      if (cp0_excode !== e_code) begin errors++; $display("[TB] FAIL rnd_excode@%0d: got %h want %h", n, cp0_excode, e_code); end
      if (cp0_badvaddr !== e_bad) begin errors++; $display("[TB] FAIL rnd_badvaddr@%0d: got %h want %h", n, cp0_badvaddr, e_bad); end
      if (cp0_bd !== e_bd) begin errors++; $display("[TB] FAIL rnd_bd@%0d: got %b want %b", n, cp0_bd, e_bd); end
      if (cp0_eret !== e_eret) begin errors++; $display("[TB] FAIL rnd_eret@%0d: got %b want %b", n, cp0_eret, e_eret); end
      if (cp0_mtc0_we !== e_mtc0) begin errors++; $display("[TB] FAIL rnd_mtc0@%0d: got %b want %b", n, cp0_mtc0_we, e_mtc0); end
      if (flush !== e_flush) begin errors++; $display("[TB] FAIL rnd_flush@%0d: got %b want %b", n, flush, e_flush); end
      if (redirect_valid !== e_rv) begin errors++; $display("[TB] FAIL rnd_rv@%0d: got %b want %b", n, redirect_valid, e_rv); end
      if (redirect_pc !== e_rpc) begin errors++; $display("[TB] FAIL rnd_rpc@%0d: got %h want %h", n, redirect_pc, e_rpc); end
      if (cp0_except && cp0_eret) begin errors++; $display("[TB] FAIL rnd_excl@%0d: except and eret both high", n); end
      tick();
    end
    clear_inputs();
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_overflow();
    test_interrupt();
    test_eret_stall();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_redirect();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
